// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared register-file sizing and writeback arbiter state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } arb_state_e;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Pending-write bit per register; a set and a clear on the same
//            register in one cycle leaves the bit set. x0 never reads busy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_idx,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] r_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && (set_idx == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (clr_en && (clr_idx == ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
      r_busy[0] <= 1'b0;
    end
  end

  assign busy = r_busy;

endmodule : regfile_scoreboard

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module   : writeback_arbiter
// Brief    : Shares the register file write port between the ALU and load
//            paths (load priority, ALU starvation guard) and tracks pending
//            writes for RAW hazard stalls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_arbiter #(
  parameter int XLEN         = regfile_pkg::XLEN,
  parameter int NUM_REGS     = regfile_pkg::NUM_REGS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  input  logic                              mem_valid,
  output logic                              mem_ready,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]                   mem_data,
  input  logic                              issue_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] issue_rd,
  output logic                              regwrite,
  output logic [regfile_pkg::REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]                   write_data,
  output logic [NUM_REGS-1:0]               busy
);

  import regfile_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  // Counter value whose increment would hit the limit: hand priority to the ALU.
  localparam logic [CNT_W-1:0] c_starve_last = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e            r_state;
  arb_state_e            w_state_next;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic [CNT_W-1:0]      w_starve_cnt_next;
  logic                  w_alu_grant;
  logic                  w_mem_grant;

  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_write_reg;
  logic [XLEN-1:0]       r_write_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= PRIO_MEM;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_starve_cnt_next = r_starve_cnt;
    case (r_state)
      PRIO_MEM: begin
        if (mem_valid && alu_valid) begin
          if (r_starve_cnt >= c_starve_last) begin
            w_state_next      = PRIO_ALU;
            w_starve_cnt_next = '0;
          end else begin
            w_starve_cnt_next = r_starve_cnt + 1'b1;
          end
        end else if (alu_valid) begin
          w_starve_cnt_next = '0;
        end
      end
      PRIO_ALU: begin
        // Either the ALU wins now or it has stopped asking; both end the boost.
        w_state_next      = PRIO_MEM;
        w_starve_cnt_next = '0;
      end
      default: begin
        w_state_next      = PRIO_MEM;
        w_starve_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    w_alu_grant = 1'b0;
    w_mem_grant = 1'b0;
    if (!reset) begin
      case (r_state)
        PRIO_ALU: begin
          if (alu_valid)      w_alu_grant = 1'b1;
          else if (mem_valid) w_mem_grant = 1'b1;
        end
        default: begin
          if (mem_valid)      w_mem_grant = 1'b1;
          else if (alu_valid) w_alu_grant = 1'b1;
        end
      endcase
    end
  end

  assign alu_ready = w_alu_grant;
  assign mem_ready = w_mem_grant;

  // Writes to x0 complete the handshake but never reach the port.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_regwrite <= 1'b0;
      if (w_alu_grant && (alu_rd != '0)) begin
        r_regwrite   <= 1'b1;
        r_write_reg  <= alu_rd;
        r_write_data <= alu_data;
      end else if (w_mem_grant && (mem_rd != '0)) begin
        r_regwrite   <= 1'b1;
        r_write_reg  <= mem_rd;
        r_write_data <= mem_data;
      end
    end
  end

  assign regwrite   = r_regwrite;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (REG_ADDR_W)
  ) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .set_en  (issue_valid && (issue_rd != '0)),
    .set_idx (issue_rd),
    .clr_en  (r_regwrite),
    .clr_idx (r_write_reg),
    .busy    (busy)
  );

endmodule : writeback_arbiter

`default_nettype wire
